mc_controller_p: RTL and testbench

MC_CONTROLLER_P -- requirements
Module: mc_controller_p

---
 rtl/mc_controller_p_if.sv | 42 ++++
 rtl/mc_controller_p.sv | 148 ++++++++++++++
 tb/tb_mc_controller_p.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_p_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface mc_controller_p_if #(
  parameter int OPC_W = 4
);
  logic [OPC_W-1:0] opcode;
  logic             jump_taken;
  logic             mem_ack;
  logic             ld_PC;
  logic             ld_IR;
  logic             ld_DI;
  logic             ld_TR;
  logic             ld_ALU;
  logic             ld_CZN;
  logic             write_en_rf;
  logic             sel_PC_src_jump;
  logic             sel_MEM_src;
  logic [1:0]       sel_RF_src;
  logic             MEM_read;
  logic             MEM_write;
  logic             busy;
  logic             error;
  logic [3:0]       state;

  modport master (
    input  opcode, jump_taken, mem_ack,
    output ld_PC, ld_IR, ld_DI, ld_TR,
    output ld_ALU, ld_CZN, write_en_rf,
    output sel_PC_src_jump, sel_MEM_src,
    output sel_RF_src, MEM_read, MEM_write,
    output busy, error, state
  );

  modport slave (
    output opcode, jump_taken, mem_ack,
    input  ld_PC, ld_IR, ld_DI, ld_TR,
    input  ld_ALU, ld_CZN, write_en_rf,
    input  sel_PC_src_jump, sel_MEM_src,
    input  sel_RF_src, MEM_read, MEM_write,
    input  busy, error, state
  );
endinterface

// File: rtl/mc_controller_p.sv
// Multi-cycle CPU control FSM with memory-wait timeout.
// Strobes decode from state and mem_ack; ERR is absorbing until reset.
module mc_controller_p #(
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input logic         clk,
  input logic         rst,
  mc_controller_p_if.master bus
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_DEC     = 4'd1,
    S_LDI_MEM = 4'd2,
    S_LDI_WB  = 4'd3,
    S_STI_MEM = 4'd4,
    S_MVR     = 4'd5,
    S_ALU_EX  = 4'd6,
    S_ALU_WB  = 4'd7,
    S_JMP     = 4'd8,
    S_ERR     = 4'd15
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op4;
  logic          ack;
  logic          mem_st;
  logic          to_hit;

  assign op4    = bus.opcode[OPC_W-1 -: 4];
  assign ack    = bus.mem_ack;
  assign mem_st = (state_q == S_IF) ||
                  (state_q == S_LDI_MEM) ||
                  (state_q == S_STI_MEM);
  assign to_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (ack)         state_d = S_DEC;
        else if (to_hit) state_d = S_ERR;
      end
      S_DEC: begin
        unique case (1'b1)
          op4[3:1] == 3'b000: state_d = S_LDI_MEM;
          op4[3:1] == 3'b001: state_d = S_STI_MEM;
          op4[3:2] == 2'b01:
            state_d = bus.jump_taken ? S_JMP : S_IF;
          op4 == 4'b1000:     state_d = S_MVR;
          default:            state_d = S_ALU_EX;
        endcase
      end
      S_LDI_MEM: begin
        if (ack)         state_d = S_LDI_WB;
        else if (to_hit) state_d = S_ERR;
      end
      S_STI_MEM: begin
        if (ack)         state_d = S_IF;
        else if (to_hit) state_d = S_ERR;
      end
      S_LDI_WB: state_d = S_IF;
      S_MVR:    state_d = S_IF;
      S_ALU_EX: state_d = S_ALU_WB;
      S_ALU_WB: state_d = S_IF;
      S_JMP:    state_d = S_IF;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IF;
    endcase
  end

  // Counter restarts on every state change, so each request gets a full window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (mem_st && !ack) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.ld_PC           = 1'b0;
    bus.ld_IR           = 1'b0;
    bus.ld_DI           = 1'b0;
    bus.ld_TR           = 1'b0;
    bus.ld_ALU          = 1'b0;
    bus.ld_CZN          = 1'b0;
    bus.write_en_rf     = 1'b0;
    bus.sel_PC_src_jump = 1'b0;
    bus.sel_MEM_src     = 1'b0;
    bus.sel_RF_src      = 2'd0;
    bus.MEM_read        = 1'b0;
    bus.MEM_write       = 1'b0;
    case (state_q)
      S_IF: begin
        bus.MEM_read = 1'b1;
        bus.ld_IR    = ack;
        bus.ld_PC    = ack;
      end
      S_DEC: bus.ld_TR = 1'b1;
      S_LDI_MEM: begin
        bus.MEM_read    = 1'b1;
        bus.sel_MEM_src = 1'b1;
        bus.ld_DI       = ack;
      end
      S_LDI_WB: begin
        bus.write_en_rf = 1'b1;
        bus.sel_RF_src  = 2'd1;
        bus.ld_CZN      = 1'b1;
      end
      S_STI_MEM: begin
        bus.MEM_write   = 1'b1;
        bus.sel_MEM_src = 1'b1;
      end
      S_MVR: begin
        bus.write_en_rf = 1'b1;
        bus.sel_RF_src  = 2'd2;
        bus.ld_CZN      = 1'b1;
      end
      S_ALU_EX: bus.ld_ALU = 1'b1;
      S_ALU_WB: begin
        bus.write_en_rf = 1'b1;
        bus.ld_CZN      = 1'b1;
      end
      S_JMP: begin
        bus.ld_PC           = 1'b1;
        bus.sel_PC_src_jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state_q != S_IF);
  assign bus.error = (state_q == S_ERR);
  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_controller_p.sv
// Table-driven bench for mc_controller_p with a per-cycle scoreboard
// plus hand sequences for timeout and asynchronous reset.
module tb_mc_controller_p;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_controller_p_if #(.OPC_W(4)) dut_if ();

  mc_controller_p #(
    .OPC_W(4), .TIMEOUT(TO), .CW(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.master)
  );

  typedef struct {
    logic [3:0] op;
    logic       jt;
    int         len;
    logic [3:0] seq [4];
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        watch   = 1'b0;
  logic        we_seen = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // {ld_PC,ld_IR,ld_DI,ld_TR,ld_ALU,ld_CZN,we,pcj,msrc,rf[1:0],rd,wr,busy,err}
  function automatic logic [14:0] exp_out(
      input logic [3:0] s, input logic a);
    logic [14:0] o;
    o = '0;
    case (s)
      4'd0:  begin o[4] = 1'b1; o[14] = a; o[13] = a; end
      4'd1:  begin o[11] = 1'b1; o[1] = 1'b1; end
      4'd2:  begin
        o[4] = 1'b1; o[6] = 1'b1; o[12] = a; o[1] = 1'b1;
      end
      4'd3:  begin
        o[8] = 1'b1; o[5:4+1] = 2'd1; o[9] = 1'b1; o[1] = 1'b1;
      end
      4'd4:  begin o[3] = 1'b1; o[6] = 1'b1; o[1] = 1'b1; end
      4'd5:  begin
        o[8] = 1'b1; o[5:4+1] = 2'd0; o[9] = 1'b1; o[1] = 1'b1;
      end
      4'd6:  begin o[10] = 1'b1; o[1] = 1'b1; end
      4'd7:  begin o[8] = 1'b1; o[9] = 1'b1; o[1] = 1'b1; end
      4'd8:  begin o[14] = 1'b1; o[7] = 1'b1; o[1] = 1'b1; end
      4'd15: begin o[1] = 1'b1; o[0] = 1'b1; end
      default: o = '0;
    endcase
    if (s == 4'd3) o[5:4] = 2'd1;
    if (s == 4'd5) o[5:4] = 2'd2;
    if (s == 4'd0 || s == 4'd2) o[3] = 1'b1;
    if (s == 4'd0 || s == 4'd2) o[4] = 1'b0;
    if (s == 4'd2) o[6] = 1'b1;
    if (s == 4'd4) begin o[3] = 1'b0; o[2] = 1'b1; end
    return o;
  endfunction

  function automatic logic [14:0] act_out();
    return {dut_if.ld_PC, dut_if.ld_IR, dut_if.ld_DI,
            dut_if.ld_TR, dut_if.ld_ALU, dut_if.ld_CZN,
            dut_if.write_en_rf, dut_if.sel_PC_src_jump,
            dut_if.sel_MEM_src, dut_if.sel_RF_src,
            dut_if.MEM_read, dut_if.MEM_write,
            dut_if.busy, dut_if.error};
  endfunction

  always @(negedge clk) begin
    logic [18:0] e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("state", {28'd0, dut_if.state}, {28'd0, e[18:15]});
      chk($sformatf("outs@s%0d", e[18:15]),
          {17'd0, act_out()}, {17'd0, e[14:0]});
    end
  end

  always @(dut_if.write_en_rf)
    if (watch && dut_if.write_en_rf) we_seen = 1'b1;

  task automatic cyc(input logic a, input logic [3:0] es);
    dut_if.mem_ack = a;
    sb_q.push_back({es, exp_out(es, a)});
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] op, input logic jt,
                     input int len, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c,
                     input logic [3:0] d);
    vec_t v;
    v.op = op; v.jt = jt; v.len = len;
    v.seq[0] = a; v.seq[1] = b; v.seq[2] = c; v.seq[3] = d;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    add(4'b0000, 1'b0, 4, 4'd0, 4'd1, 4'd2, 4'd3);
    add(4'b0001, 1'b0, 4, 4'd0, 4'd1, 4'd2, 4'd3);
    add(4'b0010, 1'b0, 3, 4'd0, 4'd1, 4'd4, 4'd0);
    add(4'b0011, 1'b0, 3, 4'd0, 4'd1, 4'd4, 4'd0);
    add(4'b1000, 1'b0, 3, 4'd0, 4'd1, 4'd5, 4'd0);
    add(4'b1001, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7);
    add(4'b1111, 1'b0, 4, 4'd0, 4'd1, 4'd6, 4'd7);
    add(4'b0100, 1'b1, 3, 4'd0, 4'd1, 4'd8, 4'd0);
    add(4'b0111, 1'b0, 2, 4'd0, 4'd1, 4'd0, 4'd0);
    add(4'b0101, 1'b1, 3, 4'd0, 4'd1, 4'd8, 4'd0);
    add(4'b0110, 1'b0, 2, 4'd0, 4'd1, 4'd0, 4'd0);

    dut_if.opcode     = 4'b0000;
    dut_if.jump_taken = 1'b0;
    dut_if.mem_ack    = 1'b0;

    #12;
    chk("rst_state", {28'd0, dut_if.state}, 32'd0);
    chk("rst_outs", {17'd0, act_out()},
        {17'd0, exp_out(4'd0, 1'b0)});
    dut_if.mem_ack = 1'b1;
    #1;
    chk("rst_outs_ack", {17'd0, act_out()},
        {17'd0, exp_out(4'd0, 1'b1)});
    dut_if.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      dut_if.opcode     = vecs[i].op;
      dut_if.jump_taken = vecs[i].jt;
      for (int k = 0; k < vecs[i].len; k++)
        cyc(1'b1, vecs[i].seq[k]);
    end

    // ack arrives on the last allowed wait cycle
    dut_if.opcode = 4'b0000;
    cyc(1'b1, 4'd0);
    cyc(1'b1, 4'd1);
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 4'd2);
    cyc(1'b1, 4'd2);
    cyc(1'b1, 4'd3);

    // store that never completes
    dut_if.opcode = 4'b0010;
    cyc(1'b1, 4'd0);
    cyc(1'b1, 4'd1);
    for (int i = 0; i < TO; i++) cyc(1'b0, 4'd4);
    cyc(1'b0, 4'd15);
    cyc(1'b1, 4'd15);
    cyc(1'b0, 4'd15);
    #2;
    rst = 1'b1;
    #1;
    chk("err_rst_state", {28'd0, dut_if.state}, 32'd0);
    chk("err_rst_outs", {17'd0, act_out()},
        {17'd0, exp_out(4'd0, 1'b0)});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset lands in the middle of ALU_EX
    dut_if.opcode = 4'b1001;
    cyc(1'b1, 4'd0);
    cyc(1'b1, 4'd1);
    watch = 1'b1;
    #2;
    chk("alu_ex_state", {28'd0, dut_if.state}, 32'd6);
    rst = 1'b1;
    #1;
    chk("alu_rst_async", {28'd0, dut_if.state}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("alu_rst_hold", {28'd0, dut_if.state}, 32'd0);
    dut_if.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    watch = 1'b0;
    chk("we_never_pulsed", {31'd0, we_seen}, 32'd0);

    dut_if.opcode = 4'b1000;
    cyc(1'b1, 4'd0);
    cyc(1'b1, 4'd1);
    cyc(1'b1, 4'd5);
    cyc(1'b0, 4'd0);
    @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
